// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle RV32I sequencing controller.
package mc_ctrl_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BRANCH, HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format straight from the opcode, independent of state.
  function automatic logic [1:0] imm_src(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: ALUOp/funct3/funct7b5 to ALUControl mapping.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0]      alu_op,
  input  logic [F3_W-1:0] funct3,
  input  logic            op_b5,
  input  logic            funct7b5,
  output logic [2:0]      alu_control_c
);

  // sub only for R-type with funct7b5 set; I-type funct7 bits are immediate.
  always_comb begin
    alu_control_c = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control_c = ALU_ADD;
      ALUOP_SUB: alu_control_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control_c = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_c = ALU_SLT;
          3'b110:  alu_control_c = ALU_OR;
          3'b111:  alu_control_c = ALU_AND;
          default: alu_control_c = ALU_ADD;
        endcase
      end
      default: alu_control_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_core_ctrl.sv
// mc_core_ctrl: multicycle RV32I sequencer; state is registered, write
// enables are Mealy on mem_ready/Zero. Optional MC_ILLEGAL_TRAP_EN traps
// unknown opcodes into HALT and adds the illegal_op output.
module mc_core_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic [F3_W-1:0] funct3,
  input  logic            funct7b5,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ImmSrc,
  output logic [2:0]      ALUControl,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic            illegal_op,
`endif
  output logic            RegWrite
);

  state_e            state_q, state_d, cur_state;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        alu_op;
  logic              fetch_req;

  assign fetch_req = (hold_q == '0);

  // Next state and hold-counter countdown.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
    case (state_q)
      FETCH:    if (fetch_req && mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           state_d = HALT;
`else
          default:           state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR, EXECI: state_d = ALUWB;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  // State and hold counter; reset restarts fetch with the hold window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      hold_q  <= HOLD_W'(RESET_PC_HOLD);
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Per-state datapath controls; reset presents FETCH selects with enables off.
  always_comb begin
    cur_state = reset ? FETCH : state_q;
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (cur_state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        mem_req   = fetch_req;
        IRWrite   = fetch_req & mem_ready;
        PCWrite   = fetch_req & mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        mem_req  = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: RegWrite = 1'b1;
      JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        PCWrite = ((funct3 == 3'b000) & Zero) | ((funct3 == 3'b001) & ~Zero);
      end
`ifdef MC_ILLEGAL_TRAP_EN
      HALT: illegal_op = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign ImmSrc = imm_src(op);

  mc_alu_dec u_alu_dec (
    .alu_op        (alu_op),
    .funct3        (funct3),
    .op_b5         (op[5]),
    .funct7b5      (funct7b5),
    .alu_control_c (ALUControl)
  );

endmodule
